// File: rtl/bus_switch_ctrl_pkg.sv
// Shared bus configuration for the registered bus switch: default widths,
// transaction FSM encoding and small sizing helpers.
package bus_switch_ctrl_pkg;

    localparam int DEF_SLAVE_NUM = 8;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    // Width of an index or counter that must hold values 0..n-1, never below 1 bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_switch_ctrl_decoder.sv
// Combinational address decoder: compares the request address against every
// slave window and reports a one-hot hit (lowest index wins) or a miss.
module bus_addr_decoder
    import bus_switch_ctrl_pkg::*;
#(
    parameter int                              SLAVE_NUM  = DEF_SLAVE_NUM,
    parameter int                              ADDR_W     = DEF_ADDR_W,
    parameter logic [SLAVE_NUM*ADDR_W-1:0]     SLAVE_BASE = '0,
    parameter logic [SLAVE_NUM*ADDR_W-1:0]     SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0]    adr_i,
    input  logic                 stb_i,
    output logic [SLAVE_NUM-1:0] hit_o,
    output logic                 miss_o
);

    logic found;

    always_comb begin
        hit_o = '0;
        found = 1'b0;
        for (int s = 0; s < SLAVE_NUM; s++) begin
            if (!found && stb_i &&
                ((adr_i & SLAVE_MASK[s*ADDR_W +: ADDR_W]) == SLAVE_BASE[s*ADDR_W +: ADDR_W])) begin
                hit_o[s] = 1'b1;
                found    = 1'b1;
            end
        end
        miss_o = stb_i && !found;
    end

endmodule

// File: rtl/bus_switch_ctrl.sv
// Registered single-master, N-slave bus switch. One transaction at a time:
// decode, select one slave until it acks or the watchdog fires, then answer.
module bus_switch_ctrl
    import bus_switch_ctrl_pkg::*;
#(
    parameter int                              SLAVE_NUM  = DEF_SLAVE_NUM,
    parameter int                              ADDR_W     = DEF_ADDR_W,
    parameter int                              DATA_W     = DEF_DATA_W,
    parameter logic [SLAVE_NUM*ADDR_W-1:0]     SLAVE_BASE = '0,
    parameter logic [SLAVE_NUM*ADDR_W-1:0]     SLAVE_MASK = '0,
    parameter int                              TIMEOUT    = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        master_stb_i,
    input  logic                        master_we_i,
    input  logic [ADDR_W-1:0]           master_adr_i,
    input  logic [DATA_W-1:0]           master_dat_i,
    output logic [DATA_W-1:0]           master_dat_o,
    output logic                        master_ack_o,
    output logic                        master_err_o,
    output logic                        err_sticky_o,
    output logic [SLAVE_NUM-1:0]        slave_cs_o,
    output logic                        slave_we_o,
    output logic [ADDR_W-1:0]           slave_adr_o,
    output logic [DATA_W-1:0]           slave_dat_o,
    input  logic [SLAVE_NUM*DATA_W-1:0] slave_dat_i,
    input  logic [SLAVE_NUM-1:0]        slave_ack_i,
    output logic [1:0]                  dbg_state_o
);

    // Handshake: the master holds stb (with we/adr/dat stable) until it sees
    // ack; ack and err are one-cycle pulses. A slave is selected by its cs bit
    // and completes by raising its ack while selected; any other ack is ignored.

    localparam int IDX_W = width_for(SLAVE_NUM);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    bus_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                sticky_q, sticky_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [SLAVE_NUM-1:0] hit;
    logic                 miss;
    logic [IDX_W-1:0]     hit_idx;
    logic                 sel_ack;
    logic [DATA_W-1:0]    sel_dat;
    logic                 timeout_hit;

    bus_addr_decoder #(
        .SLAVE_NUM  (SLAVE_NUM),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .adr_i  (master_adr_i),
        .stb_i  (master_stb_i),
        .hit_o  (hit),
        .miss_o (miss)
    );

    always_comb begin
        hit_idx = '0;
        for (int s = 0; s < SLAVE_NUM; s++) begin
            if (hit[s]) begin
                hit_idx = IDX_W'(s);
            end
        end
    end

    assign sel_ack     = slave_ack_i[idx_q];
    assign sel_dat     = slave_dat_i[idx_q*DATA_W +: DATA_W];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdat_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (master_stb_i && !miss) begin
                    state_d = ST_ACCESS;
                    idx_d   = hit_idx;
                    we_d    = master_we_i;
                    adr_d   = master_adr_i;
                    wdat_d  = master_dat_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (miss) begin
                    state_d  = ST_RESP;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    sticky_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                // A real ack outranks a watchdog expiry in the same cycle.
                if (sel_ack) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : sel_dat;
                end else if (timeout_hit) begin
                    state_d  = ST_RESP;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    sticky_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        slave_cs_o   = '0;
        master_ack_o = (state_q == ST_RESP);
        master_err_o = (state_q == ST_RESP) && err_q;
        if (state_q == ST_ACCESS) begin
            slave_cs_o[idx_q] = 1'b1;
        end
        master_dat_o = rdata_q;
        err_sticky_o = sticky_q;
        slave_we_o   = we_q;
        slave_adr_o  = adr_q;
        slave_dat_o  = wdat_q;
        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_bus_switch_ctrl.sv
// Self-checking bench for bus_switch_ctrl: slave windows 0x0..0x7 in the top
// nibble, slave 5 overlapping slave 3, watchdog of 4 cycles.
module tb_bus_switch_ctrl;

    localparam int SN = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam logic [SN*AW-1:0] BASE = {32'h7000_0000, 32'h6000_0000, 32'h3000_0000, 32'h4000_0000,
                                         32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [SN*AW-1:0] MASK = {SN{32'hF000_0000}};

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              master_stb_i = 1'b0;
    logic              master_we_i = 1'b0;
    logic [AW-1:0]     master_adr_i = '0;
    logic [DW-1:0]     master_dat_i = '0;
    logic [DW-1:0]     master_dat_o;
    logic              master_ack_o;
    logic              master_err_o;
    logic              err_sticky_o;
    logic [SN-1:0]     slave_cs_o;
    logic              slave_we_o;
    logic [AW-1:0]     slave_adr_o;
    logic [DW-1:0]     slave_dat_o;
    logic [SN*DW-1:0]  slave_dat_i = '0;
    logic [SN-1:0]     slave_ack_i = '0;
    logic [1:0]        dbg_state_o;

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];

    bus_switch_ctrl #(
        .SLAVE_NUM  (SN),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .master_stb_i (master_stb_i),
        .master_we_i  (master_we_i),
        .master_adr_i (master_adr_i),
        .master_dat_i (master_dat_i),
        .master_dat_o (master_dat_o),
        .master_ack_o (master_ack_o),
        .master_err_o (master_err_o),
        .err_sticky_o (err_sticky_o),
        .slave_cs_o   (slave_cs_o),
        .slave_we_o   (slave_we_o),
        .slave_adr_o  (slave_adr_o),
        .slave_dat_o  (slave_dat_o),
        .slave_dat_i  (slave_dat_i),
        .slave_ack_i  (slave_ack_i),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard: every completion pulse pops one expected {err, data} entry.
    always @(negedge clk_i) begin
        logic [DW:0] exp;
        if (rst_i && master_ack_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack got err=%0b dat=%h with empty queue", master_err_o, master_dat_o);
            end else begin
                exp = exp_q.pop_front();
                if ({master_err_o, master_dat_o} !== exp) begin
                    errors++;
                    $display("FAIL sb_response got err=%0b dat=%h want err=%0b dat=%h",
                             master_err_o, master_dat_o, exp[DW], exp[DW-1:0]);
                end
            end
        end
    end

    task automatic fill_slave_data(input int slot, input logic [DW-1:0] value);
        for (int s = 0; s < SN; s++) begin
            slave_dat_i[s*DW +: DW] = $urandom;
        end
        slave_dat_i[slot*DW +: DW] = value;
    endtask

    // ack_delay: index of the cs cycle in which ack_slave raises ack (-1 = never).
    task automatic run_txn(input string name, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] wdat, input logic [SN-1:0] exp_cs,
                           input int ack_slave, input int ack_delay, input logic [DW-1:0] rdata,
                           input logic exp_err, input logic [DW-1:0] exp_dat,
                           input int exp_lat, input bit drop_stb);
        int lat;
        int cs_cycles;
        int exp_cs_cycles;
        bit done;
        exp_q.push_back({exp_err, exp_dat});
        @(negedge clk_i);
        master_stb_i = 1'b1;
        master_we_i  = we;
        master_adr_i = adr;
        master_dat_i = wdat;
        lat = 0;
        cs_cycles = 0;
        done = 1'b0;
        while (!done && lat < 30) begin
            @(negedge clk_i);
            lat++;
            slave_ack_i = '0;
            if (drop_stb) master_stb_i = 1'b0;
            if (master_ack_o) begin
                done = 1'b1;
                master_stb_i = 1'b0;
            end else if (slave_cs_o != '0) begin
                checks++;
                if (slave_cs_o !== exp_cs) begin
                    errors++;
                    $display("FAIL %s cs got %b want %b", name, slave_cs_o, exp_cs);
                end
                if (cs_cycles == 0) begin
                    checks++;
                    if ({slave_we_o, slave_adr_o, slave_dat_o} !== {we, adr, wdat}) begin
                        errors++;
                        $display("FAIL %s slave_bus got we=%0b adr=%h dat=%h want we=%0b adr=%h dat=%h",
                                 name, slave_we_o, slave_adr_o, slave_dat_o, we, adr, wdat);
                    end
                end
                if (cs_cycles == ack_delay) begin
                    fill_slave_data(ack_slave, rdata);
                    slave_ack_i[ack_slave] = 1'b1;
                end
                cs_cycles++;
            end
        end
        master_stb_i = 1'b0;
        slave_ack_i  = '0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s no_ack got none within 30 cycles want ack", name);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        end
        exp_cs_cycles = (exp_cs == '0) ? 0 : exp_lat - 1;
        checks++;
        if (cs_cycles != exp_cs_cycles) begin
            errors++;
            $display("FAIL %s cs_cycles got %0d want %0d", name, cs_cycles, exp_cs_cycles);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({master_dat_o, master_ack_o, master_err_o, err_sticky_o, slave_cs_o,
             slave_we_o, slave_adr_o, slave_dat_o, dbg_state_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got cs=%b ack=%0b dat=%h state=%0d want all zero",
                     slave_cs_o, master_ack_o, master_dat_o, dbg_state_o);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_read();
        run_txn("read_s2", 1'b0, 32'h2000_0010, 32'h0, 8'b0000_0100, 2, 2, 32'hDEAD_BEEF,
                1'b0, 32'hDEAD_BEEF, 4, 1'b0);
        repeat (3) @(negedge clk_i);
        checks++;
        if (master_dat_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_hold dat got %h want %h", master_dat_o, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_write();
        run_txn("write_s1", 1'b1, 32'h1000_0004, 32'h1234_5678, 8'b0000_0010, 1, 0, 32'hAAAA_5555,
                1'b0, 32'h0, 2, 1'b0);
    endtask

    task automatic test_miss();
        checks++;
        if (err_sticky_o !== 1'b0) begin
            errors++;
            $display("FAIL sticky_before_miss got %0b want 0", err_sticky_o);
        end
        run_txn("miss", 1'b0, 32'hF000_0000, 32'h0, 8'b0, 0, -1, 32'h0, 1'b1, 32'h0, 1, 1'b0);
        checks++;
        if (err_sticky_o !== 1'b1) begin
            errors++;
            $display("FAIL sticky_after_miss got %0b want 1", err_sticky_o);
        end
    endtask

    task automatic test_timeout();
        run_txn("timeout_s4", 1'b0, 32'h4000_0020, 32'h0, 8'b0001_0000, 4, -1, 32'h0,
                1'b1, 32'h0, TO + 1, 1'b0);
        run_txn("ack_at_timeout", 1'b0, 32'h6000_0000, 32'h0, 8'b0100_0000, 6, TO - 1, 32'h0BAD_F00D,
                1'b0, 32'h0BAD_F00D, TO + 1, 1'b0);
    endtask

    task automatic test_overlap();
        run_txn("overlap_foreign_ack", 1'b0, 32'h3000_0100, 32'h0, 8'b0000_1000, 5, 0, 32'h5555_5555,
                1'b1, 32'h0, TO + 1, 1'b0);
        run_txn("overlap_own_ack", 1'b0, 32'h3000_0104, 32'h0, 8'b0000_1000, 3, 1, 32'h3333_CAFE,
                1'b0, 32'h3333_CAFE, 3, 1'b0);
    endtask

    task automatic test_stb_drop();
        run_txn("stb_drop", 1'b0, 32'h7000_0008, 32'h0, 8'b1000_0000, 7, 1, 32'h7777_0001,
                1'b0, 32'h7777_0001, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ack_seen;
        exp_q.push_back({1'b0, 32'hB2B0_0001});
        exp_q.push_back({1'b0, 32'hB2B0_0004});
        @(negedge clk_i);
        master_stb_i = 1'b1;
        master_we_i  = 1'b0;
        master_adr_i = 32'h0000_0100;
        ack_seen = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_i);
            ack_seen[i-1] = master_ack_o;
            slave_ack_i = slave_cs_o;
            fill_slave_data(0, 32'hB2B0_0000 + DW'(i));
            if (i == 6) master_stb_i = 1'b0;
        end
        slave_ack_i = '0;
        checks++;
        if (ack_seen !== 6'b010010) begin
            errors++;
            $display("FAIL back_to_back ack_pattern got %b want %b", ack_seen, 6'b010010);
        end
    endtask

    task automatic test_random();
        int r;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        int dly;
        for (int n = 0; n < 6; n++) begin
            r = $urandom_range(0, 6);
            if (r >= 5) r++;
            d = $urandom;
            a = {4'(r), 28'($urandom)};
            dly = $urandom_range(0, 2);
            run_txn("random_read", 1'b0, a, 32'h0, 8'(1 << r), r, dly, d, 1'b0, d, dly + 2, 1'b0);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk_i);
        master_stb_i = 1'b1;
        master_we_i  = 1'b0;
        master_adr_i = 32'h2000_0040;
        @(negedge clk_i);
        checks++;
        if (slave_cs_o !== 8'b0000_0100) begin
            errors++;
            $display("FAIL midreset_cs_before got %b want %b", slave_cs_o, 8'b0000_0100);
        end
        rst_i = 1'b0;
        master_stb_i = 1'b0;
        #1;
        checks++;
        if ({slave_cs_o, master_ack_o, master_err_o, err_sticky_o, master_dat_o, dbg_state_o} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got cs=%b ack=%0b sticky=%0b dat=%h want all zero",
                     slave_cs_o, master_ack_o, err_sticky_o, master_dat_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        run_txn("after_reset", 1'b0, 32'h2000_0044, 32'h0, 8'b0000_0100, 2, 0, 32'hFEED_0002,
                1'b0, 32'hFEED_0002, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_miss();
        test_timeout();
        test_overlap();
        test_stb_drop();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        repeat (2) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
